// File: rtl/ysyx_22040237_idu_pipe.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_idu_pipe
// Pipelined decode stage sitting between IFU and EXU. Decodes one RV32I/RV64I
// instruction (plus RV64 W-ops) per cycle and registers the result into an
// ID/EX holding register under a valid/ready handshake. It stalls on a
// load-use hazard against the load in EX and drops its contents on a branch
// redirect (flush_i).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid_i/in_ready_o IFU -> ID handshake
//   inst_i, pc_i          instruction and its PC
//   rs1_idx_o/rs2_idx_o   combinational register-file read indices
//   rs1_data_i/rs2_data_i register-file read data for those indices
//   flush_i               redirect from EXU, kills the ID/EX register
//   ex_ld_pending_i/_rd_i load currently in EX and its destination
//   out_valid_o/out_ready_i ID -> EX handshake
//   pc_o, rd_idx_o, rd_wr_en_o, op1_o, op2_o, op1_jp_o, op2_jp_o,
//   exu_info_bus_o, invalid_inst_o  registered decode results
//
// exu_info_bus_o[2:0] selects the unit (000 ALU, 001 BJP, 010 LSU, 011 SYS);
// the upper bits are a one-hot operation field whose meaning depends on the
// unit. INFO_W must be at least 15 to hold the ALU WORD bit.
// ---------------------------------------------------------------------------
module ysyx_22040237_idu_pipe #(
    parameter int XLEN     = 64,
    parameter int INFO_W   = 16,
    parameter bit W_OPS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       inst_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    output logic [4:0]        rs1_idx_o,
    output logic [4:0]        rs2_idx_o,
    input  logic              flush_i,
    input  logic              ex_ld_pending_i,
    input  logic [4:0]        ex_ld_rd_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   pc_o,
    output logic [4:0]        rd_idx_o,
    output logic              rd_wr_en_o,
    output logic [XLEN-1:0]   op1_o,
    output logic [XLEN-1:0]   op2_o,
    output logic [XLEN-1:0]   op1_jp_o,
    output logic [XLEN-1:0]   op2_jp_o,
    output logic [INFO_W-1:0] exu_info_bus_o,
    output logic              invalid_inst_o
);

    localparam bit IS64   = (XLEN == 64);
    localparam bit W_ON   = W_OPS_EN && IS64;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM32= 7'b0011011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [63:0] CONST_FOUR  = 64'd4;

    // Maps funct3 (and the funct7 "alternate" bit) onto the one-hot ALU field.
    function automatic logic [15:0] alu_info(input logic [2:0] f3, input logic alt);
        logic [15:0] r;
        r = 16'd0;
        case (f3)
            3'b000:  r[alt ? 4 : 3]  = 1'b1;   // ADD / SUB
            3'b001:  r[5]            = 1'b1;   // SLL
            3'b010:  r[6]            = 1'b1;   // SLT
            3'b011:  r[7]            = 1'b1;   // SLTU
            3'b100:  r[8]            = 1'b1;   // XOR
            3'b101:  r[alt ? 10 : 9] = 1'b1;   // SRA / SRL
            3'b110:  r[11]           = 1'b1;   // OR
            3'b111:  r[12]           = 1'b1;   // AND
            default: r               = 16'd0;
        endcase
        return r;
    endfunction

    // ---------------- field extraction and immediates ----------------
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [4:0]  rd_s;
    logic [63:0] imm_i64_s, imm_s64_s, imm_b64_s, imm_u64_s, imm_j64_s;
    logic [63:0] shamt64_s, shamt32_s;

    assign opcode_s  = inst_i[6:0];
    assign funct3_s  = inst_i[14:12];
    assign funct7_s  = inst_i[31:25];
    assign rd_s      = inst_i[11:7];
    assign rs1_idx_o = inst_i[19:15];
    assign rs2_idx_o = inst_i[24:20];

    // Immediates are built at 64 bits and sliced, so RV32 needs no special case.
    assign imm_i64_s = {{52{inst_i[31]}}, inst_i[31:20]};
    assign imm_s64_s = {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b64_s = {{52{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u64_s = {{32{inst_i[31]}}, inst_i[31:12], 12'd0};
    assign imm_j64_s = {{44{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign shamt64_s = {58'd0, inst_i[25:20]};
    assign shamt32_s = {59'd0, inst_i[24:20]};

    // ---------------- decode ----------------
    logic            legal_s;
    logic            rs1_need_s;
    logic            rs2_need_s;
    logic            wr_s;
    logic [XLEN-1:0] op1_s, op2_s, op1_jp_s, op2_jp_s;
    logic [15:0]     info16_s;
    logic            shift_ok_s;

    // Combinational decode of inst_i into operands, info bus and legality.
    always_comb begin
        legal_s    = 1'b0;
        rs1_need_s = 1'b0;
        rs2_need_s = 1'b0;
        wr_s       = 1'b0;
        op1_s      = '0;
        op2_s      = '0;
        op1_jp_s   = '0;
        op2_jp_s   = '0;
        info16_s   = 16'd0;
        shift_ok_s = 1'b0;
        case (opcode_s)
            OPC_LUI: begin
                legal_s      = 1'b1;
                wr_s         = 1'b1;
                op2_s        = imm_u64_s[XLEN-1:0];
                info16_s[13] = 1'b1;
            end
            OPC_AUIPC: begin
                legal_s     = 1'b1;
                wr_s        = 1'b1;
                op1_s       = pc_i;
                op2_s       = imm_u64_s[XLEN-1:0];
                info16_s[3] = 1'b1;
            end
            OPC_JAL: begin
                legal_s       = 1'b1;
                wr_s          = 1'b1;
                op1_s         = pc_i;
                op2_s         = CONST_FOUR[XLEN-1:0];
                op1_jp_s      = pc_i;
                op2_jp_s      = imm_j64_s[XLEN-1:0];
                info16_s[2:0] = 3'b001;
                info16_s[3]   = 1'b1;
            end
            OPC_JALR: begin
                rs1_need_s    = 1'b1;
                legal_s       = (funct3_s == 3'b000);
                wr_s          = 1'b1;
                op1_s         = pc_i;
                op2_s         = CONST_FOUR[XLEN-1:0];
                op1_jp_s      = rs1_data_i;
                op2_jp_s      = imm_i64_s[XLEN-1:0];
                info16_s[2:0] = 3'b001;
                info16_s[4]   = 1'b1;
            end
            OPC_BRANCH: begin
                rs1_need_s    = 1'b1;
                rs2_need_s    = 1'b1;
                legal_s       = 1'b1;
                op1_s         = rs1_data_i;
                op2_s         = rs2_data_i;
                op1_jp_s      = pc_i;
                op2_jp_s      = imm_b64_s[XLEN-1:0];
                info16_s[2:0] = 3'b001;
                case (funct3_s)
                    3'b000:  info16_s[5]  = 1'b1;
                    3'b001:  info16_s[6]  = 1'b1;
                    3'b100:  info16_s[7]  = 1'b1;
                    3'b101:  info16_s[8]  = 1'b1;
                    3'b110:  info16_s[9]  = 1'b1;
                    3'b111:  info16_s[10] = 1'b1;
                    default: legal_s      = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                rs1_need_s    = 1'b1;
                wr_s          = 1'b1;
                op1_s         = rs1_data_i;
                op2_s         = imm_i64_s[XLEN-1:0];
                info16_s[2:0] = 3'b010;
                info16_s[3]   = 1'b1;
                info16_s[5]   = funct3_s[2];
                info16_s[7:6] = funct3_s[1:0];
                // LD and LWU exist only on RV64; there is no LDU.
                case (funct3_s)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
                    3'b011, 3'b110:                         legal_s = IS64;
                    default:                                legal_s = 1'b0;
                endcase
            end
            OPC_STORE: begin
                rs1_need_s    = 1'b1;
                rs2_need_s    = 1'b1;
                op1_s         = rs1_data_i;
                op2_s         = imm_s64_s[XLEN-1:0];
                info16_s[2:0] = 3'b010;
                info16_s[4]   = 1'b1;
                info16_s[7:6] = funct3_s[1:0];
                case (funct3_s)
                    3'b000, 3'b001, 3'b010: legal_s = 1'b1;
                    3'b011:                 legal_s = IS64;
                    default:                legal_s = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                rs1_need_s = 1'b1;
                wr_s       = 1'b1;
                op1_s      = rs1_data_i;
                op2_s      = imm_i64_s[XLEN-1:0];
                if (funct3_s == 3'b001 || funct3_s == 3'b101) begin
                    // RV64 shifts take a 6-bit shamt, so funct7 shrinks to 6 bits.
                    if (IS64) begin
                        shift_ok_s = (inst_i[31:26] == 6'b000000) ||
                                     (funct3_s == 3'b101 && inst_i[31:26] == 6'b010000);
                        op2_s      = shamt64_s[XLEN-1:0];
                    end else begin
                        shift_ok_s = (funct7_s == 7'b0000000) ||
                                     (funct3_s == 3'b101 && funct7_s == 7'b0100000);
                        op2_s      = shamt32_s[XLEN-1:0];
                    end
                    legal_s  = shift_ok_s;
                    info16_s = alu_info(funct3_s, inst_i[30]);
                end else begin
                    legal_s  = 1'b1;
                    info16_s = alu_info(funct3_s, 1'b0);
                end
            end
            OPC_OP: begin
                rs1_need_s = 1'b1;
                rs2_need_s = 1'b1;
                wr_s       = 1'b1;
                op1_s      = rs1_data_i;
                op2_s      = rs2_data_i;
                legal_s    = (funct7_s == 7'b0000000) ||
                             (funct7_s == 7'b0100000 &&
                              (funct3_s == 3'b000 || funct3_s == 3'b101));
                info16_s   = alu_info(funct3_s, inst_i[30]);
            end
            OPC_OPIMM32: begin
                rs1_need_s = 1'b1;
                wr_s       = 1'b1;
                op1_s      = rs1_data_i;
                case (funct3_s)
                    3'b000: begin
                        legal_s = W_ON;
                        op2_s   = imm_i64_s[XLEN-1:0];
                    end
                    3'b001: begin
                        legal_s = W_ON && (funct7_s == 7'b0000000);
                        op2_s   = shamt32_s[XLEN-1:0];
                    end
                    3'b101: begin
                        legal_s = W_ON && (funct7_s == 7'b0000000 || funct7_s == 7'b0100000);
                        op2_s   = shamt32_s[XLEN-1:0];
                    end
                    default: legal_s = 1'b0;
                endcase
                info16_s     = alu_info(funct3_s, (funct3_s == 3'b101) && inst_i[30]);
                info16_s[14] = 1'b1;
            end
            OPC_OP32: begin
                rs1_need_s = 1'b1;
                rs2_need_s = 1'b1;
                wr_s       = 1'b1;
                op1_s      = rs1_data_i;
                op2_s      = rs2_data_i;
                case (funct3_s)
                    3'b000, 3'b101: legal_s = W_ON && (funct7_s == 7'b0000000 || funct7_s == 7'b0100000);
                    3'b001:         legal_s = W_ON && (funct7_s == 7'b0000000);
                    default:        legal_s = 1'b0;
                endcase
                info16_s     = alu_info(funct3_s, inst_i[30]);
                info16_s[14] = 1'b1;
            end
            OPC_SYSTEM: begin
                legal_s       = (inst_i == INST_EBREAK);
                info16_s[2:0] = 3'b011;
                info16_s[3]   = 1'b1;
            end
            default: legal_s = 1'b0;
        endcase
        // Illegal encodings still flow down the pipe, but carry no operation.
        if (!legal_s) begin
            wr_s     = 1'b0;
            op1_s    = '0;
            op2_s    = '0;
            op1_jp_s = '0;
            op2_jp_s = '0;
            info16_s = 16'd0;
        end else begin
            wr_s     = wr_s && (rd_s != 5'd0);
        end
    end

    // ---------------- handshake ----------------
    logic out_valid_r;
    logic advance_s;
    logic hazard_s;
    logic capture_s;

    assign advance_s  = !out_valid_r || out_ready_i;
    assign hazard_s   = ex_ld_pending_i && (ex_ld_rd_i != 5'd0) &&
                        ((rs1_need_s && ex_ld_rd_i == rs1_idx_o) ||
                         (rs2_need_s && ex_ld_rd_i == rs2_idx_o));
    assign in_ready_o = advance_s && !hazard_s && !flush_i;
    assign capture_s  = in_valid_i && in_ready_o;

    // ---------------- ID/EX register ----------------
    logic [XLEN-1:0]   pc_r, op1_r, op2_r, op1_jp_r, op2_jp_r;
    logic [4:0]        rd_r;
    logic              wr_r;
    logic [INFO_W-1:0] info_r;
    logic              invalid_r;

    // ID/EX holding register: flush/bubble clears it, capture loads it, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            pc_r        <= '0;
            rd_r        <= 5'd0;
            wr_r        <= 1'b0;
            op1_r       <= '0;
            op2_r       <= '0;
            op1_jp_r    <= '0;
            op2_jp_r    <= '0;
            info_r      <= '0;
            invalid_r   <= 1'b0;
        end else if (flush_i || (advance_s && !capture_s)) begin
            out_valid_r <= 1'b0;
            pc_r        <= '0;
            rd_r        <= 5'd0;
            wr_r        <= 1'b0;
            op1_r       <= '0;
            op2_r       <= '0;
            op1_jp_r    <= '0;
            op2_jp_r    <= '0;
            info_r      <= '0;
            invalid_r   <= 1'b0;
        end else if (capture_s) begin
            out_valid_r <= 1'b1;
            pc_r        <= pc_i;
            rd_r        <= rd_s;
            wr_r        <= wr_s;
            op1_r       <= op1_s;
            op2_r       <= op2_s;
            op1_jp_r    <= op1_jp_s;
            op2_jp_r    <= op2_jp_s;
            info_r      <= INFO_W'(info16_s);
            invalid_r   <= !legal_s;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid_o    = out_valid_r;
    assign pc_o           = pc_r;
    assign rd_idx_o       = rd_r;
    assign rd_wr_en_o     = wr_r;
    assign op1_o          = op1_r;
    assign op2_o          = op2_r;
    assign op1_jp_o       = op1_jp_r;
    assign op2_jp_o       = op2_jp_r;
    assign exu_info_bus_o = info_r;
    assign invalid_inst_o = invalid_r;

endmodule

// File: tb/tb_ysyx_22040237_idu_pipe.sv
// Directed bench for ysyx_22040237_idu_pipe. An RV64 instance carries the main
// sequence; an RV32 instance shares the same stimulus to check W-op and wide
// shift rejection. A tiny register-file model supplies read data.
module tb_ysyx_22040237_idu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        flush;
    logic        ld_pend;
    logic [4:0]  ld_rd;
    logic        out_ready;

    logic [63:0] rs1_data, rs2_data;
    logic [4:0]  rs1_idx, rs2_idx;
    logic        in_ready, out_valid, wr_en, invalid;
    logic [63:0] pc_o, op1, op2, op1_jp, op2_jp;
    logic [4:0]  rd_idx;
    logic [15:0] info;

    logic [31:0] rs1_data32, rs2_data32;
    logic [4:0]  rs1_idx32, rs2_idx32;
    logic        in_ready32, out_valid32, wr_en32, invalid32;
    logic [31:0] pc_o32, op1_32, op2_32, op1_jp32, op2_jp32;
    logic [4:0]  rd_idx32;
    logic [15:0] info32;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Register-file model: x0 reads zero, others a recognisable pattern.
    function automatic logic [63:0] rf(input logic [4:0] idx);
        return (idx == 5'd0) ? 64'd0 : {32'hCAFE_0000, 27'd0, idx};
    endfunction

    assign rs1_data   = rf(rs1_idx);
    assign rs2_data   = rf(rs2_idx);
    assign rs1_data32 = rf(rs1_idx32) & 64'h0000_0000_FFFF_FFFF;
    assign rs2_data32 = rf(rs2_idx32) & 64'h0000_0000_FFFF_FFFF;

    ysyx_22040237_idu_pipe #(.XLEN(64), .INFO_W(16), .W_OPS_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .inst_i(inst), .pc_i(pc), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
        .rs1_idx_o(rs1_idx), .rs2_idx_o(rs2_idx), .flush_i(flush),
        .ex_ld_pending_i(ld_pend), .ex_ld_rd_i(ld_rd), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .pc_o(pc_o), .rd_idx_o(rd_idx), .rd_wr_en_o(wr_en),
        .op1_o(op1), .op2_o(op2), .op1_jp_o(op1_jp), .op2_jp_o(op2_jp),
        .exu_info_bus_o(info), .invalid_inst_o(invalid)
    );

    ysyx_22040237_idu_pipe #(.XLEN(32), .INFO_W(16), .W_OPS_EN(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready32),
        .inst_i(inst), .pc_i(pc[31:0]), .rs1_data_i(rs1_data32), .rs2_data_i(rs2_data32),
        .rs1_idx_o(rs1_idx32), .rs2_idx_o(rs2_idx32), .flush_i(flush),
        .ex_ld_pending_i(ld_pend), .ex_ld_rd_i(ld_rd), .out_valid_o(out_valid32),
        .out_ready_i(out_ready), .pc_o(pc_o32), .rd_idx_o(rd_idx32), .rd_wr_en_o(wr_en32),
        .op1_o(op1_32), .op2_o(op2_32), .op1_jp_o(op1_jp32), .op2_jp_o(op2_jp32),
        .exu_info_bus_o(info32), .invalid_inst_o(invalid32)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; sample point is 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        inst      = 32'h0000_0013;
        pc        = 64'd0;
        flush     = 1'b0;
        ld_pend   = 1'b0;
        ld_rd     = 5'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_pc", pc_o, 64'd0);
        chk("rst_info", {48'd0, info}, 64'd0);
        rst_n = 1'b1;
        step();

        // addi x1,x0,5
        in_valid = 1'b1;
        inst     = 32'h0050_0093;
        pc       = 64'h0000_0000_8000_0000;
        #1;
        chk("addi_ready", {63'd0, in_ready}, 64'd1);
        step();
        chk("addi_valid", {63'd0, out_valid}, 64'd1);
        chk("addi_pc", pc_o, 64'h0000_0000_8000_0000);
        chk("addi_op1", op1, 64'd0);
        chk("addi_op2", op2, 64'd5);
        chk("addi_rd", {59'd0, rd_idx}, 64'd1);
        chk("addi_wr", {63'd0, wr_en}, 64'd1);
        chk("addi_info", {48'd0, info}, 64'h0008);

        // lw x2,0(x1)
        inst = 32'h0000_A103;
        pc   = 64'h0000_0000_8000_0004;
        step();
        chk("lw_info", {48'd0, info}, 64'h008A);
        chk("lw_op1", op1, rf(5'd1));
        chk("lw_op2", op2, 64'd0);

        // add x3,x2,x2 behind the load: one stall cycle, then accepted
        inst    = 32'h0021_01B3;
        pc      = 64'h0000_0000_8000_0008;
        ld_pend = 1'b1;
        ld_rd   = 5'd2;
        #1;
        chk("hz_ready", {63'd0, in_ready}, 64'd0);
        step();
        chk("hz_bubble", {63'd0, out_valid}, 64'd0);
        ld_pend = 1'b0;
        #1;
        chk("hz_release", {63'd0, in_ready}, 64'd1);
        step();
        chk("add_valid", {63'd0, out_valid}, 64'd1);
        chk("add_op1", op1, rf(5'd2));
        chk("add_op2", op2, rf(5'd2));
        chk("add_rd", {59'd0, rd_idx}, 64'd3);
        chk("add_info", {48'd0, info}, 64'h0008);

        // beq x1,x2,8
        inst = 32'h0020_8463;
        pc   = 64'h0000_0000_8000_0010;
        step();
        chk("beq_jp1", op1_jp, 64'h0000_0000_8000_0010);
        chk("beq_jp2", op2_jp, 64'd8);
        chk("beq_info", {48'd0, info}, 64'h0021);
        chk("beq_wr", {63'd0, wr_en}, 64'd0);
        chk("beq_op1", op1, rf(5'd1));

        // jal x1,16
        inst = 32'h0100_00EF;
        pc   = 64'h0000_0000_8000_0020;
        step();
        chk("jal_op1", op1, 64'h0000_0000_8000_0020);
        chk("jal_op2", op2, 64'd4);
        chk("jal_jp2", op2_jp, 64'd16);
        chk("jal_info", {48'd0, info}, 64'h0009);

        // lui x5,0x80000: U immediate sign-extends to 64 bits
        inst = 32'h8000_02B7;
        pc   = 64'h0000_0000_8000_0024;
        step();
        chk("lui_op1", op1, 64'd0);
        chk("lui_op2", op2, 64'hFFFF_FFFF_8000_0000);
        chk("lui_info", {48'd0, info}, 64'h2000);
        chk("lui_rd", {59'd0, rd_idx}, 64'd5);

        // addw x3,x1,x2: legal on RV64, illegal on RV32
        inst = 32'h0020_81BB;
        pc   = 64'h0000_0000_8000_0028;
        step();
        chk("addw_info", {48'd0, info}, 64'h4008);
        chk("addw_inv", {63'd0, invalid}, 64'd0);
        chk("addw32_inv", {63'd0, invalid32}, 64'd1);
        chk("addw32_wr", {63'd0, wr_en32}, 64'd0);
        chk("addw32_info", {48'd0, info32}, 64'd0);
        chk("addw32_valid", {63'd0, out_valid32}, 64'd1);

        // srai x4,x1,33: 6-bit shamt on RV64, illegal on RV32
        inst = 32'h4210_D213;
        pc   = 64'h0000_0000_8000_002C;
        step();
        chk("srai_info", {48'd0, info}, 64'h0400);
        chk("srai_op2", op2, 64'd33);
        chk("srai32_inv", {63'd0, invalid32}, 64'd1);

        // all-ones encoding is illegal but still valid in the pipe
        inst = 32'hFFFF_FFFF;
        pc   = 64'h0000_0000_8000_0030;
        step();
        chk("ill_valid", {63'd0, out_valid}, 64'd1);
        chk("ill_inv", {63'd0, invalid}, 64'd1);
        chk("ill_info", {48'd0, info}, 64'd0);
        chk("ill_wr", {63'd0, wr_en}, 64'd0);

        // backpressure: outputs hold for three cycles, then flush clears
        inst = 32'h0050_0093;
        pc   = 64'h0000_0000_8000_0100;
        step();
        out_ready = 1'b0;
        inst      = 32'h0021_01B3;
        pc        = 64'h0000_0000_8000_0104;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", {63'd0, in_ready}, 64'd0);
            step();
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_pc", pc_o, 64'h0000_0000_8000_0100);
            chk("bp_op2", op2, 64'd5);
        end
        flush = 1'b1;
        #1;
        chk("fl_ready", {63'd0, in_ready}, 64'd0);
        step();
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        flush     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        // asynchronous reset mid-stream, then ebreak
        in_valid = 1'b1;
        inst     = 32'h0010_0073;
        pc       = 64'h0000_0000_8000_0200;
        step();
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ebrk_valid", {63'd0, out_valid}, 64'd1);
        chk("ebrk_info", {48'd0, info}, 64'h000B);
        chk("ebrk_inv", {63'd0, invalid}, 64'd0);
        chk("ebrk_wr", {63'd0, wr_en}, 64'd0);
        in_valid = 1'b0;
        step();
        chk("end_valid", {63'd0, out_valid}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
